// File: rtl/daq_pkg.sv
// daq_pkg: shared DMA beat width, status counter widths and drain FSM states
package daq_pkg;
   localparam int DMA_W     = 64;
   localparam int PKT_FWD_W = 32;
   localparam int OVS_W     = 16;
   typedef enum logic {ST_IDLE, ST_DRAIN} drain_st_e;
endpackage

// File: rtl/daq_sdp_ram.sv
// daq_sdp_ram: inferred simple dual-port RAM with registered read
//   clk_i, rst_i           : clock, async reset (clears the read register only)
//   we_i/waddr_i/wdata_i   : write port
//   re_i/raddr_i/rdata_o   : read port, data valid the cycle after re_i, held otherwise
module daq_sdp_ram #(
   parameter int WIDTH      = 65,
   parameter int DEPTH_LOG2 = 9
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] waddr_i,
   input  logic [WIDTH-1:0]      wdata_i,
   input  logic                  re_i,
   input  logic [DEPTH_LOG2-1:0] raddr_i,
   output logic [WIDTH-1:0]      rdata_o
);
   logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
   logic [WIDTH-1:0] rdata_q;
   always_ff @(posedge clk_i)
      if (we_i) mem_q[waddr_i] <= wdata_i;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   assign rdata_o = rdata_q;
endmodule

// File: rtl/daq_dma_packet_fifo.sv
// daq_dma_packet_fifo: store-and-forward / cut-through packet FIFO between ldmx_daq DMA output and host DMA
//   dma_clk_i, reset_i                     : clock, async active-high reset
//   s_valid_i/s_ready_o/s_data_i/s_last_i  : input beat stream from ldmx_daq
//   m_valid_o/m_ready_i/m_data_o/m_last_o  : registered FWFT output stream to host
//   store_forward_i                        : 1 holds packets until complete, 0 is cut-through
//   fill_level_o, pkt_count_o              : beats held (incl. output register), complete packets held
//   pkts_forwarded_o, oversize_count_o     : delivered packets (wrapping), drain fallbacks (saturating)
module daq_dma_packet_fifo
   import daq_pkg::*;
#(
   parameter int DEPTH_LOG2 = 9
) (
   input  logic                  dma_clk_i,
   input  logic                  reset_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [DMA_W-1:0]      s_data_i,
   input  logic                  s_last_i,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [DMA_W-1:0]      m_data_o,
   output logic                  m_last_o,
   input  logic                  store_forward_i,
   output logic [DEPTH_LOG2:0]   fill_level_o,
   output logic [DEPTH_LOG2:0]   pkt_count_o,
   output logic [PKT_FWD_W-1:0]  pkts_forwarded_o,
   output logic [OVS_W-1:0]      oversize_count_o
);
   localparam int CW = DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]         fill_q, fill_d, pkt_q, pkt_d;
   logic [PKT_FWD_W-1:0]  fwd_q, fwd_d;
   logic [OVS_W-1:0]      ovs_q, ovs_d;
   logic                  m_valid_q, m_valid_d;
   drain_st_e             st_q, st_d;
   logic                  acc, hs, hs_last, out_last, ram_ne, drain_set, rel, rd_en;
   logic [DMA_W:0]        rdata;
   // The RAM read register doubles as the output register, giving the two-cycle latency.
   daq_sdp_ram #(.WIDTH(DMA_W + 1), .DEPTH_LOG2(DEPTH_LOG2)) u_ram (
      .clk_i   (dma_clk_i),
      .rst_i   (reset_i),
      .we_i    (acc),
      .waddr_i (wptr_q),
      .wdata_i ({s_last_i, s_data_i}),
      .re_i    (rd_en),
      .raddr_i (rptr_q),
      .rdata_o (rdata)
   );
   assign {m_last_o, m_data_o} = rdata;
   assign m_valid_o        = m_valid_q;
   assign s_ready_o        = !fill_q[DEPTH_LOG2];
   assign fill_level_o     = fill_q;
   assign pkt_count_o      = pkt_q;
   assign pkts_forwarded_o = fwd_q;
   assign oversize_count_o = ovs_q;
   always_comb begin
      acc       = s_valid_i && s_ready_o;
      hs        = m_valid_q && m_ready_i;
      hs_last   = hs && m_last_o;
      out_last  = m_valid_q && m_last_o;
      // Beats in RAM = fill minus the one possibly held in the output register.
      ram_ne    = fill_q != CW'(m_valid_q);
      drain_set = (st_q == ST_IDLE) && store_forward_i && (fill_q == DEPTH) && (pkt_q == '0);
      // Complete packets still in RAM exclude one whose last beat already sits in the output
      // register; draining stops once the oversize packet's last beat has been read out.
      rel       = store_forward_i ? (pkt_q > CW'(out_last)) || ((st_q == ST_DRAIN) && !out_last) : 1'b1;
      rd_en     = ram_ne && rel && (!m_valid_q || m_ready_i);
      m_valid_d = rd_en || (m_valid_q && !m_ready_i);
      wptr_d    = wptr_q + DEPTH_LOG2'(acc);
      rptr_d    = rptr_q + DEPTH_LOG2'(rd_en);
      fill_d    = fill_q + CW'(acc) - CW'(hs);
      pkt_d     = pkt_q + CW'(acc && s_last_i) - CW'(hs_last);
      fwd_d     = fwd_q + PKT_FWD_W'(hs_last);
      ovs_d     = ovs_q + OVS_W'(drain_set && (ovs_q != '1));
      st_d      = (st_q == ST_IDLE) ? (drain_set ? ST_DRAIN : ST_IDLE) : (hs_last ? ST_IDLE : ST_DRAIN);
   end
   always_ff @(posedge dma_clk_i or posedge reset_i)
      if (reset_i) st_q <= ST_IDLE;
      else st_q <= st_d;
   always_ff @(posedge dma_clk_i or posedge reset_i)
      if (reset_i) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         fill_q    <= '0;
         pkt_q     <= '0;
         fwd_q     <= '0;
         ovs_q     <= '0;
         m_valid_q <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         fill_q    <= fill_d;
         pkt_q     <= pkt_d;
         fwd_q     <= fwd_d;
         ovs_q     <= ovs_d;
         m_valid_q <= m_valid_d;
      end
endmodule

// File: tb/tb_daq_dma_packet_fifo.sv
// tb_daq_dma_packet_fifo: directed self-checking bench for daq_dma_packet_fifo
module tb_daq_dma_packet_fifo;
   logic        dma_clk = 1'b0;
   logic        reset = 1'b1;
   logic        s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0, store_forward = 1'b0;
   logic [63:0] s_data = '0;
   logic        s_ready, m_valid, m_last;
   logic [63:0] m_data;
   logic [9:0]  fill_level, pkt_count;
   logic [31:0] pkts_forwarded;
   logic [15:0] oversize_count;
   int checks = 0, failures = 0, cyc = 0;
   logic [64:0] acc_q[$], out_q[$];
   int acc_cyc[$], out_cyc[$];
   bit ok;
   int n_acc, bad;
   daq_dma_packet_fifo #(.DEPTH_LOG2(9)) dut (
      .dma_clk_i        (dma_clk),
      .reset_i          (reset),
      .s_valid_i        (s_valid),
      .s_ready_o        (s_ready),
      .s_data_i         (s_data),
      .s_last_i         (s_last),
      .m_valid_o        (m_valid),
      .m_ready_i        (m_ready),
      .m_data_o         (m_data),
      .m_last_o         (m_last),
      .store_forward_i  (store_forward),
      .fill_level_o     (fill_level),
      .pkt_count_o      (pkt_count),
      .pkts_forwarded_o (pkts_forwarded),
      .oversize_count_o (oversize_count)
   );
   always #5 dma_clk = ~dma_clk;
   always @(posedge dma_clk) cyc <= cyc + 1;
   // Scoreboard capture: accepted input beats and output handshakes, sampled mid-cycle.
   always @(negedge dma_clk)
      if (!reset) begin
         if (s_valid && s_ready) begin acc_q.push_back({s_last, s_data}); acc_cyc.push_back(cyc); end
         if (m_valid && m_ready) begin out_q.push_back({m_last, m_data}); out_cyc.push_back(cyc); end
      end
   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end
   function automatic logic [63:0] dv(input int s, input int i);
      return {16'hB0B0, 16'(s), 32'(i)};
   endfunction
   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic send(input logic [63:0] d, input logic l, input int limit, output bit acc_ok);
      s_valid = 1'b1; s_data = d; s_last = l; acc_ok = 1'b0;
      for (int c = 0; c < limit && !acc_ok; c++) begin
         @(negedge dma_clk);
         acc_ok = s_ready;
         @(posedge dma_clk); #1;
      end
      if (acc_ok) s_valid = 1'b0;
   endtask
   task automatic wait_idle(input string tag);
      int c = 0;
      @(negedge dma_clk);
      while ((m_valid || fill_level != 0) && c < 3000) begin @(negedge dma_clk); c++; end
      checks++;
      assert (c < 3000) else begin
         failures++;
         $error("FAIL %s_drain_timeout observed=%0d cycles required=<3000", tag, c);
      end
      @(posedge dma_clk); #1;
   endtask
   task automatic cmp_stream(input string tag, output int bad_lat);
      bad_lat = 0;
      chk({tag, "_beats"}, 65'(out_q.size()), 65'(acc_q.size()));
      for (int i = 0; i < out_q.size() && i < acc_q.size(); i++) begin
         chk($sformatf("%s_beat%0d", tag, i), out_q[i], acc_q[i]);
         if (out_cyc[i] - acc_cyc[i] != 2) bad_lat++;
      end
      acc_q.delete(); out_q.delete(); acc_cyc.delete(); out_cyc.delete();
   endtask
   task automatic do_reset();
      s_valid = 1'b0; m_ready = 1'b0;
      reset = 1'b1;
      @(posedge dma_clk); @(posedge dma_clk); #1;
      reset = 1'b0;
      acc_q.delete(); out_q.delete(); acc_cyc.delete(); out_cyc.delete();
   endtask
   initial begin
      #2;
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_fill", fill_level, 0);
      chk("rst_pkt", pkt_count, 0);
      chk("rst_fwd", pkts_forwarded, 0);
      chk("rst_ovs", oversize_count, 0);
      @(posedge dma_clk); @(posedge dma_clk); #1;
      reset = 1'b0;
      // store-and-forward, single 4-beat packet
      store_forward = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < 3; i++) send(dv(1, i), 1'b0, 30, ok);
      @(negedge dma_clk);
      chk("sf_hold_valid", m_valid, 0);
      chk("sf_hold_pkt", pkt_count, 0);
      @(posedge dma_clk); #1;
      send(dv(1, 3), 1'b1, 30, ok);
      @(negedge dma_clk);
      chk("sf_n1_pkt", pkt_count, 1);
      chk("sf_n1_valid", m_valid, 0);
      @(negedge dma_clk);
      chk("sf_n2_valid", m_valid, 1);
      chk("sf_n2_data", m_data, dv(1, 0));
      @(posedge dma_clk); #1;
      wait_idle("sf");
      chk("sf_first_latency", 65'(out_cyc.size() > 0 ? out_cyc[0] : -1), 65'(acc_cyc[3] + 2));
      chk("sf_pkt_end", pkt_count, 0);
      chk("sf_fwd", pkts_forwarded, 1);
      cmp_stream("sf", bad);
      // cut-through, 20 back-to-back 7-beat packets
      do_reset();
      store_forward = 1'b0; m_ready = 1'b1;
      for (int p = 0; p < 20; p++)
         for (int b = 0; b < 7; b++) send(dv(2, p * 7 + b), b == 6, 30, ok);
      wait_idle("ct");
      chk("ct_fwd", pkts_forwarded, 20);
      cmp_stream("ct", bad);
      chk("ct_latency_violations", 65'(bad), 0);
      // back-pressure: 600 beats offered with the host stalled
      do_reset();
      store_forward = 1'b0;
      n_acc = 600;
      for (int i = 0; i < 600; i++) begin
         send(dv(3, i), (i % 50 == 49) || (i == 599), 30, ok);
         if (!ok) begin n_acc = i; break; end
      end
      chk("bp_accepted", 65'(n_acc), 512);
      chk("bp_fill", fill_level, 512);
      chk("bp_s_ready", s_ready, 0);
      chk("bp_m_valid", m_valid, 1);
      chk("bp_m_data_held", m_data, dv(3, 0));
      chk("bp_m_last_held", m_last, 0);
      chk("bp_pkt", pkt_count, 10);
      if (n_acc < 600) begin
         m_ready = 1'b1;
         @(negedge dma_clk);
         chk("bp_s_ready_k", s_ready, 0);
         @(negedge dma_clk);
         chk("bp_s_ready_k1", s_ready, 1);
         @(posedge dma_clk); #1;
         if (acc_q.size() == n_acc) send(dv(3, n_acc), 1'b0, 30, ok);
         s_valid = 1'b0;
         for (int i = n_acc + 1; i < 600; i++) send(dv(3, i), (i % 50 == 49) || (i == 599), 30, ok);
      end
      m_ready = 1'b1;
      wait_idle("bp");
      chk("bp_fwd", pkts_forwarded, 12);
      cmp_stream("bp", bad);
      // oversize 700-beat packet in store-and-forward, then a 3-beat packet
      do_reset();
      store_forward = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < 512; i++) send(dv(4, i), 1'b0, 30, ok);
      @(negedge dma_clk);
      chk("ovs_fill_full", fill_level, 512);
      chk("ovs_no_valid", m_valid, 0);
      chk("ovs_s_ready", s_ready, 0);
      @(posedge dma_clk); #1;
      for (int i = 512; i < 700; i++) send(dv(4, i), i == 699, 30, ok);
      wait_idle("ovs");
      chk("ovs_count", oversize_count, 1);
      chk("ovs_fwd", pkts_forwarded, 1);
      cmp_stream("ovs", bad);
      send(dv(5, 0), 1'b0, 30, ok);
      send(dv(5, 1), 1'b0, 30, ok);
      repeat (5) @(negedge dma_clk);
      chk("ovs_next_held", m_valid, 0);
      chk("ovs_next_fill", fill_level, 2);
      @(posedge dma_clk); #1;
      send(dv(5, 2), 1'b1, 30, ok);
      wait_idle("ovs2");
      chk("ovs2_fwd", pkts_forwarded, 2);
      chk("ovs2_count", oversize_count, 1);
      cmp_stream("ovs2", bad);
      // simultaneous s_last accept and m_last handshake
      do_reset();
      store_forward = 1'b0; m_ready = 1'b1;
      send(dv(6, 0), 1'b1, 30, ok);
      send(dv(6, 1), 1'b0, 30, ok);
      send(dv(6, 2), 1'b1, 30, ok);
      @(negedge dma_clk);
      chk("sim_pkt", pkt_count, 1);
      chk("sim_fill", fill_level, 2);
      chk("sim_same_cycle", 65'(out_cyc.size() > 0 ? out_cyc[0] : -1), 65'(acc_cyc[2]));
      @(posedge dma_clk); #1;
      wait_idle("sim");
      chk("sim_fwd", pkts_forwarded, 2);
      cmp_stream("sim", bad);
      // reset mid-packet
      do_reset();
      store_forward = 1'b0; m_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(dv(7, i), 1'b0, 30, ok);
      chk("mid_fill", fill_level, 5);
      chk("mid_m_data", m_data, dv(7, 0));
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_fill", fill_level, 0);
      chk("mid_rst_s_ready", s_ready, 1);
      chk("mid_rst_m_valid", m_valid, 0);
      chk("mid_rst_m_data", m_data, 0);
      chk("mid_rst_m_last", m_last, 0);
      chk("mid_rst_pkt", pkt_count, 0);
      @(posedge dma_clk); @(posedge dma_clk); #1;
      reset = 1'b0;
      acc_q.delete(); out_q.delete(); acc_cyc.delete(); out_cyc.delete();
      store_forward = 1'b1; m_ready = 1'b1;
      send(dv(8, 0), 1'b0, 30, ok);
      send(dv(8, 1), 1'b1, 30, ok);
      wait_idle("post");
      chk("post_fwd", pkts_forwarded, 1);
      cmp_stream("post", bad);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/daq_dma_packet_fifo.md
# daq_dma_packet_fifo

Store-and-forward packet FIFO between the `ldmx_daq` DMA output (64-bit `dma_valid`/`dma_ready`/`dma_data`/`dma_done` stream) and the host DMA engine. It absorbs host back-pressure so event readout from the DAQ buffer pages is not stalled. In store-and-forward mode it presents a packet only once the whole packet is resident. Oversize packets fall back to cut-through, which makes deadlock impossible. It provides packet and occupancy counters for status registers.

## Interface
- `DEPTH_LOG2`, 9: FIFO depth is 2^DEPTH_LOG2 64-bit beats.
- `dma_clk` in 1: the single clock. All logic is on this clock.
- `reset` in 1: asynchronous, active-high reset.
- `s_valid` in 1: input beat valid. Driven by `ldmx_daq` `dma_valid`.
- `s_ready` out 1: input ready. Drives `ldmx_daq` `dma_ready`.
- `s_data` in 64: input beat.
- `s_last` in 1: last beat of packet. Driven by `dma_done`.
- `m_valid` out 1: output beat valid.
- `m_ready` in 1: host ready.
- `m_data` out 64: output beat, registered.
- `m_last` out 1: last beat of packet, registered.
- `store_forward` in 1: 1 selects store-and-forward, 0 selects cut-through. Software changes it only while idle.
- `fill_level` out DEPTH_LOG2+1: beats currently held, including the output register.
- `pkt_count` out DEPTH_LOG2+1: complete packets held.
- `pkts_forwarded` out 32: packets delivered to host, wrapping.
- `oversize_count` out 16: cut-through fallbacks taken, saturating.

## Operation
- Storage is a simple dual-port RAM: 2^DEPTH_LOG2 × 65 bits (data plus last flag).
- The write pointer and read pointer are DEPTH_LOG2 bits wide and wrap modulo depth.
- An input beat is accepted when `s_valid && s_ready`. It is written at the write pointer, and the write pointer increments.
- `s_ready` = (`fill_level` < 2^DEPTH_LOG2). It is computed from registered count only, with no combinational path from `m_ready`.
- `pkt_count` updates as follows:
  - +1 on an accepted beat with `s_last`.
  - −1 on an output handshake with `m_last`.
  - Both in the same cycle: unchanged.
- Release condition for reading the next beat from RAM into the output register:
  - Cut-through: RAM is non-empty.
  - Store-and-forward: `pkt_count` > 0, or the drain flag is set.
- Drain flag:
  - Set when store-and-forward mode is active, `fill_level` equals depth, and `pkt_count` = 0. `oversize_count` increments at the same time.
  - Cleared when the output handshake carries `m_last`.
- Read and output path:
  - A one-entry output register with FWFT behaviour holds `m_valid`, `m_data` and `m_last`.
  - The register is loaded when it is empty, or when it is being emptied this cycle (`m_valid && m_ready`).
  - While `m_valid` = 1 and `m_ready` = 0, `m_data` and `m_last` are held stable.
- `pkts_forwarded` increments on each output handshake with `m_last`.
- `fill_level` counts accepted input beats minus output handshakes. The two events in the same cycle cancel.

## Timing
- Reset values:
  - `s_ready` = 1.
  - `m_valid` = 0, `m_data` = 0, `m_last` = 0.
  - All counters and pointers = 0.
  - Drain flag = 0.
- Cut-through latency: a beat accepted in cycle N appears on `m_valid` in cycle N+2, covering the RAM read plus the output register.
- Store-and-forward latency: the first beat of a packet appears in cycle N+2, where N is the cycle in which its `s_last` beat was accepted.
- Steady-state throughput is one beat per cycle when `m_ready` is held at 1. The read pipeline must be bubble-free, using a prefetch stage or a skid register.
- Full boundary:
  - `s_ready` falls in the cycle after the write that fills the FIFO.
  - It rises in the cycle after the first output handshake.
- Empty boundary: no read is issued. `m_valid` drops after the last held beat hands off.
- Wrap-around: pointers roll over from 2^DEPTH_LOG2−1 to 0 with no gap.
- Reset mid-packet: everything clears, and partial packets are discarded. No `m_last` is ever emitted for a discarded packet.

## Structure
- Shared package `daq_pkg`: DMA beat width (64) and the counter widths for `pkts_forwarded` and `oversize_count`.
- Sub-module `daq_sdp_ram` holds the storage. It is an inferred simple dual-port RAM with registered read, with parameters for width and depth.
- All other logic lives in the top module: pointers, counters, drain FSM and output register.
- Drain FSM states:
  - IDLE → DRAIN on the set condition above.
  - DRAIN → IDLE on an output handshake with `m_last`.

## Test plan
- Store-and-forward, single 4-beat packet, `m_ready` = 1:
  - `m_valid` stays 0 until `s_last` is accepted in cycle N.
  - The 4 beats then appear in order starting at N+2.
  - `pkt_count` goes 0→1→0. `pkts_forwarded` = 1.
- Cut-through, 20 back-to-back packets of 7 beats each, `m_ready` = 1:
  - Output matches input beat-for-beat with exactly 2 cycles of latency and no bubbles.
  - `pkts_forwarded` = 20.
- Back-pressure, `m_ready` = 0, 600 beats offered with DEPTH_LOG2 = 9:
  - `s_ready` drops after 512 accepted beats. `fill_level` = 512.
  - The output register holds its first beat stable.
  - After `m_ready` = 1, all beats emerge in order with pointers wrapping correctly.
- Oversize packet of 700 beats in store-and-forward mode, `m_ready` = 1:
  - Drain starts at `fill_level` = 512. `oversize_count` = 1.
  - The full 700-beat packet is delivered.
  - A following 3-beat packet is again held until its last beat.
- Simultaneous events:
  - Input `s_last` and output `m_last` handshake in the same cycle → `pkt_count` unchanged.
  - Input beat and output handshake in the same cycle → `fill_level` unchanged.
- Reset asserted mid-packet after 5 beats: all outputs return to reset values immediately (asynchronous). A subsequent 2-beat packet is delivered correctly with `pkts_forwarded` = 1.
